// File: rtl/jlsemi_rst_seq_pkg.sv
// rtl/jlsemi_rst_seq_pkg.sv - shared state encoding and default sizing for the reset sequencer
package jlsemi_rst_seq_pkg;

    // Status readback encoding of the sequencer FSM
    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_WAIT   = 3'd1,
        ST_REL    = 3'd2,
        ST_DONE   = 3'd3,
        ST_ASSERT = 3'd4
    } seq_state_e;

    localparam int DEF_NUM_DOM  = 4;
    localparam int DEF_DLY_W    = 8;
    localparam int DEF_HOLD_CYC = 8;

endpackage

// File: rtl/jlsemi_util_async_reset_low_sync.sv
// rtl/jlsemi_util_async_reset_low_sync.sv - 2-flop active-low reset synchronizer with scan override
module jlsemi_util_async_reset_low_sync (
    input  logic clk_i,
    input  logic rst_n_i,
    input  logic dft_scan_rstn_ctrl_i,
    input  logic dft_scan_rstn_i,
    output logic rst_n_o
);

    logic       w_arst_n;
    logic [1:0] r_sync;

    // In scan mode the tester owns the reset directly, both as clear and as output
    assign w_arst_n = dft_scan_rstn_ctrl_i ? dft_scan_rstn_i : rst_n_i;

    // Assert immediately, release after two clock edges
    always_ff @(posedge clk_i or negedge w_arst_n) begin
        if (!w_arst_n) begin
            r_sync <= 2'b00;
        end else begin
            r_sync <= {r_sync[0], 1'b1};
        end
    end

    assign rst_n_o = dft_scan_rstn_ctrl_i ? dft_scan_rstn_i : r_sync[1];

endmodule

// File: rtl/jlsemi_util_reset_seq_ctrl.sv
// rtl/jlsemi_util_reset_seq_ctrl.sv - ordered multi-domain reset release with sw reset handshake (option: JLSEMI_RST_SEQ_DFT_EN)
module jlsemi_util_reset_seq_ctrl
    import jlsemi_rst_seq_pkg::*;
#(
    parameter int NUM_DOM  = DEF_NUM_DOM,
    parameter int DLY_W    = DEF_DLY_W,
    parameter int HOLD_CYC = DEF_HOLD_CYC
) (
    input  logic               clk_i,
    input  logic               rst_n_i,
    input  logic [DLY_W-1:0]   cfg_dly_i,
    input  logic               sw_rst_req_i,
`ifdef JLSEMI_RST_SEQ_DFT_EN
    input  logic               dft_rstnsync_scan_rstn_ctrl,
    input  logic               dft_rstnsync_scan_rstn,
`endif
    output logic               sw_rst_ack_o,
    output logic [NUM_DOM-1:0] rst_n_o,
    output logic               seq_done_o,
    output logic [2:0]         state_o
);

    localparam int                 IDX_W     = (NUM_DOM > 1) ? $clog2(NUM_DOM) : 1;
    localparam logic [IDX_W-1:0]   LAST_IDX  = IDX_W'(NUM_DOM - 1);
    localparam logic [DLY_W-1:0]   HOLD_LOAD = DLY_W'(HOLD_CYC - 1);

    logic               w_rst_int_n;
    logic               w_dft_ctrl;
    logic               w_dft_rstn;

    seq_state_e         r_state, w_state_nxt;
    logic [IDX_W-1:0]   r_idx, w_idx_nxt;
    logic [DLY_W-1:0]   r_cnt, w_cnt_nxt;
    logic               r_req_taken, w_req_taken_nxt;
    logic [NUM_DOM-1:0] r_rst_n, w_rst_n_nxt;
    logic               r_seq_done, w_seq_done_nxt;
    logic               r_ack, w_ack_nxt;

`ifdef JLSEMI_RST_SEQ_DFT_EN
    assign w_dft_ctrl = dft_rstnsync_scan_rstn_ctrl;
    assign w_dft_rstn = dft_rstnsync_scan_rstn;
`else
    assign w_dft_ctrl = 1'b0;
    assign w_dft_rstn = 1'b0;
`endif

    jlsemi_util_async_reset_low_sync u_rst_sync (
        .clk_i                (clk_i),
        .rst_n_i              (rst_n_i),
        .dft_scan_rstn_ctrl_i (w_dft_ctrl),
        .dft_scan_rstn_i      (w_dft_rstn),
        .rst_n_o              (w_rst_int_n)
    );

    // State, counter and registered outputs; all cleared by the synchronized reset
    always_ff @(posedge clk_i or negedge w_rst_int_n) begin
        if (!w_rst_int_n) begin
            r_state     <= ST_IDLE;
            r_idx       <= '0;
            r_cnt       <= '0;
            r_req_taken <= 1'b0;
            r_rst_n     <= '0;
            r_seq_done  <= 1'b0;
            r_ack       <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_idx       <= w_idx_nxt;
            r_cnt       <= w_cnt_nxt;
            r_req_taken <= w_req_taken_nxt;
            r_rst_n     <= w_rst_n_nxt;
            r_seq_done  <= w_seq_done_nxt;
            r_ack       <= w_ack_nxt;
        end
    end

    // Next-state: WAIT gap, one-cycle REL per domain, DONE services the sw request, ASSERT holds all low
    always_comb begin
        w_state_nxt     = r_state;
        w_idx_nxt       = r_idx;
        w_cnt_nxt       = r_cnt;
        w_req_taken_nxt = r_req_taken;
        w_rst_n_nxt     = r_rst_n;
        w_seq_done_nxt  = 1'b0;
        w_ack_nxt       = (r_state == ST_DONE) && r_req_taken;
        case (r_state)
            ST_IDLE: begin
                w_state_nxt = ST_WAIT;
                w_idx_nxt   = '0;
                w_cnt_nxt   = cfg_dly_i;
            end
            ST_WAIT: begin
                if (r_cnt != '0) begin
                    w_cnt_nxt = r_cnt - 1'b1;
                end else begin
                    w_state_nxt = ST_REL;
                end
            end
            ST_REL: begin
                w_rst_n_nxt[r_idx] = 1'b1;
                if (r_idx == LAST_IDX) begin
                    w_state_nxt = ST_DONE;
                end else begin
                    w_idx_nxt   = r_idx + 1'b1;
                    w_cnt_nxt   = cfg_dly_i;
                    w_state_nxt = ST_WAIT;
                end
            end
            ST_DONE: begin
                w_seq_done_nxt = 1'b1;
                if (!sw_rst_req_i) begin
                    // Request must return low before another one is honoured
                    w_req_taken_nxt = 1'b0;
                end else if (!r_req_taken) begin
                    w_state_nxt     = ST_ASSERT;
                    w_req_taken_nxt = 1'b1;
                    w_rst_n_nxt     = '0;
                    w_seq_done_nxt  = 1'b0;
                    w_cnt_nxt       = HOLD_LOAD;
                end
            end
            ST_ASSERT: begin
                if (r_cnt != '0) begin
                    w_cnt_nxt = r_cnt - 1'b1;
                end else begin
                    w_state_nxt = ST_WAIT;
                    w_idx_nxt   = '0;
                    w_cnt_nxt   = cfg_dly_i;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

`ifdef JLSEMI_RST_SEQ_DFT_EN
    assign rst_n_o = w_dft_ctrl ? {NUM_DOM{w_dft_rstn}} : r_rst_n;
`else
    assign rst_n_o = r_rst_n;
`endif

    assign seq_done_o   = r_seq_done;
    assign sw_rst_ack_o = r_ack;
    assign state_o      = r_state;

endmodule
